// File: rtl/sdram_wr_data_path.sv
// sdram_wr_data_path: buffers registered host write words and byte masks in a
// small FIFO and replays one burst onto the SDRAM DQ/DQM pins per WRITE strobe.
module sdram_wr_data_path #(
  parameter int data_size = 32,
  parameter int dqm_size  = 4,
  parameter int fifo_aw   = 3
) (
  input  logic                 clk0,
  input  logic                 reset,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [data_size-1:0] datain2,
  input  logic [dqm_size-1:0]  dm_in,
  input  logic                 wr_start,
  input  logic [2:0]           burst_code,
  input  logic                 clr_err,
  output logic [data_size-1:0] dq_out,
  output logic                 dq_oe,
  output logic [dqm_size-1:0]  dqm_out,
  output logic                 wr_busy,
  output logic [fifo_aw:0]     fifo_count,
  output logic                 underrun,
  output logic                 start_err
);

  localparam int depth = 2 ** fifo_aw;
  localparam logic [fifo_aw:0] full_count = {1'b1, {fifo_aw{1'b0}}};

  typedef enum logic [1:0] {IDLE, BURST, TURN} state_t;

  state_t state, state_nx;
  logic [2:0] beat_cnt, beat_cnt_nx;
  logic [2:0] beats_m1;
  logic       beat;
  logic       start_err_evt;

  logic [dqm_size+data_size-1:0] mem [depth];
  logic [fifo_aw-1:0] wptr, rptr;
  logic               push, pop, fifo_empty;

  assign wr_ready   = (fifo_count != full_count);
  assign fifo_empty = (fifo_count == '0);
  assign push       = wr_valid && wr_ready;
  assign pop        = beat && !fifo_empty;
  assign wr_busy    = (state != IDLE);

  // Burst length code to (beats - 1); codes above 3 saturate at 8 beats
  always_comb begin
    beats_m1 = 3'd7;
    case (burst_code)
      3'd0:    beats_m1 = 3'd0;
      3'd1:    beats_m1 = 3'd1;
      3'd2:    beats_m1 = 3'd3;
      default: beats_m1 = 3'd7;
    endcase
  end

  // Sequencer: 'beat' marks an edge that loads a beat into the pin registers,
  // so the first beat lands on the pins the cycle after wr_start is sampled
  always_comb begin
    state_nx      = state;
    beat_cnt_nx   = beat_cnt;
    beat          = 1'b0;
    start_err_evt = 1'b0;
    case (state)
      IDLE: begin
        if (wr_start) begin
          beat        = 1'b1;
          beat_cnt_nx = beats_m1;
          state_nx    = BURST;
        end
      end
      BURST: begin
        start_err_evt = wr_start;
        if (beat_cnt == 3'd0) begin
          state_nx = TURN;
        end else begin
          beat        = 1'b1;
          beat_cnt_nx = beat_cnt - 3'd1;
        end
      end
      TURN: begin
        start_err_evt = wr_start;
        state_nx      = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State and beat counter registers
  always_ff @(posedge clk0) begin
    if (reset) begin
      state    <= IDLE;
      beat_cnt <= 3'd0;
    end else begin
      state    <= state_nx;
      beat_cnt <= beat_cnt_nx;
    end
  end

  // FIFO pointers and occupancy; a full FIFO refuses pushes even when popping
  always_ff @(posedge clk0) begin
    if (reset) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // FIFO storage holds {mask, data}; contents need no reset
  always_ff @(posedge clk0) begin
    if (push) mem[wptr] <= {dm_in, datain2};
  end

  // Pin registers: an empty FIFO at a beat drives a fully masked zero word
  always_ff @(posedge clk0) begin
    if (reset) begin
      dq_out  <= '0;
      dq_oe   <= 1'b0;
      dqm_out <= '0;
    end else if (beat) begin
      dq_oe <= 1'b1;
      if (pop) begin
        {dqm_out, dq_out} <= mem[rptr];
      end else begin
        dq_out  <= '0;
        dqm_out <= '1;
      end
    end else begin
      dq_oe   <= 1'b0;
      dqm_out <= '0;
    end
  end

  // Sticky error flags; a new event wins over a simultaneous clear
  always_ff @(posedge clk0) begin
    if (reset) begin
      underrun  <= 1'b0;
      start_err <= 1'b0;
    end else begin
      underrun  <= (beat && fifo_empty) || (underrun && !clr_err);
      start_err <= start_err_evt || (start_err && !clr_err);
    end
  end

endmodule

// File: tb/tb_sdram_wr_data_path.sv
// tb_sdram_wr_data_path: directed test of the SDRAM write data path with
// hand-computed expected beats, masks, counts and flags.
module tb_sdram_wr_data_path;

  logic        clk0;
  logic        reset;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] datain2;
  logic [3:0]  dm_in;
  logic        wr_start;
  logic [2:0]  burst_code;
  logic        clr_err;
  logic [31:0] dq_out;
  logic        dq_oe;
  logic [3:0]  dqm_out;
  logic        wr_busy;
  logic [3:0]  fifo_count;
  logic        underrun;
  logic        start_err;

  int test_count = 0;
  int fail_count = 0;

  logic [31:0] exp_data [8];
  logic [3:0]  exp_mask [8];

  sdram_wr_data_path #(.data_size(32), .dqm_size(4), .fifo_aw(3)) dut (
    .clk0      (clk0),
    .reset     (reset),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .datain2   (datain2),
    .dm_in     (dm_in),
    .wr_start  (wr_start),
    .burst_code(burst_code),
    .clr_err   (clr_err),
    .dq_out    (dq_out),
    .dq_oe     (dq_oe),
    .dqm_out   (dqm_out),
    .wr_busy   (wr_busy),
    .fifo_count(fifo_count),
    .underrun  (underrun),
    .start_err (start_err)
  );

  // Free-running controller clock
  initial clk0 = 1'b0;
  always #5 clk0 = ~clk0;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    test_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk0);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] d, input logic [3:0] m,
                               input logic s, input logic [2:0] c, input logic clr);
    wr_valid   = v;
    datain2    = d;
    dm_in      = m;
    wr_start   = s;
    burst_code = c;
    clr_err    = clr;
    tick();
    wr_valid = 1'b0;
    wr_start = 1'b0;
    clr_err  = 1'b0;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, 3'd0, 1'b0);
  endtask

  task automatic pushWord(input logic [31:0] d, input logic [3:0] m);
    applyStimulus(1'b1, d, m, 1'b0, 3'd0, 1'b0);
  endtask

  // Issues wr_start and checks n beats against exp_data/exp_mask, then TURN and IDLE
  task automatic runBurst(input logic [2:0] code, input int n, input string tag);
    applyStimulus(1'b0, 32'h0, 4'h0, 1'b1, code, 1'b0);
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("%s_oe%0d", tag, i), dq_oe, 1'b1);
      checkOutput($sformatf("%s_dq%0d", tag, i), dq_out, exp_data[i]);
      checkOutput($sformatf("%s_dqm%0d", tag, i), dqm_out, exp_mask[i]);
      checkOutput($sformatf("%s_busy%0d", tag, i), wr_busy, 1'b1);
      idleCycle();
    end
    checkOutput({tag, "_turn_oe"}, dq_oe, 1'b0);
    checkOutput({tag, "_turn_dqm"}, dqm_out, 4'h0);
    checkOutput({tag, "_turn_hold"}, dq_out, exp_data[n-1]);
    checkOutput({tag, "_turn_busy"}, wr_busy, 1'b1);
    idleCycle();
    checkOutput({tag, "_idle_busy"}, wr_busy, 1'b0);
  endtask

  // Directed sequence following the test plan
  initial begin
    reset = 1'b1; wr_valid = 1'b0; datain2 = '0; dm_in = '0;
    wr_start = 1'b0; burst_code = '0; clr_err = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    checkOutput("rst_oe", dq_oe, 1'b0);
    checkOutput("rst_dq", dq_out, 32'h0);
    checkOutput("rst_dqm", dqm_out, 4'h0);
    checkOutput("rst_busy", wr_busy, 1'b0);
    checkOutput("rst_count", fifo_count, 4'd0);
    checkOutput("rst_flags", {underrun, start_err}, 2'b00);
    checkOutput("rst_ready", wr_ready, 1'b1);

    // 1: four words, burst of 4
    for (int k = 1; k <= 4; k++) pushWord(32'(k) * 32'h11111111, 4'h0);
    checkOutput("t1_count", fifo_count, 4'd4);
    for (int i = 0; i < 4; i++) begin
      exp_data[i] = 32'(i + 1) * 32'h11111111;
      exp_mask[i] = 4'h0;
    end
    runBurst(3'd2, 4, "t1");
    checkOutput("t1_count_end", fifo_count, 4'd0);
    checkOutput("t1_underrun", underrun, 1'b0);

    // 2: overfill, ninth word dropped, burst of 8
    for (int k = 1; k <= 8; k++) begin
      checkOutput($sformatf("t2_ready%0d", k), wr_ready, 1'b1);
      pushWord(32'hA0000000 + 32'(k), 4'h0);
    end
    checkOutput("t2_full_ready", wr_ready, 1'b0);
    checkOutput("t2_full_count", fifo_count, 4'd8);
    pushWord(32'hA0000009, 4'h0);
    checkOutput("t2_ninth_count", fifo_count, 4'd8);
    for (int i = 0; i < 8; i++) begin
      exp_data[i] = 32'hA0000000 + 32'(i + 1);
      exp_mask[i] = 4'h0;
    end
    runBurst(3'd3, 8, "t2");
    checkOutput("t2_count_end", fifo_count, 4'd0);

    // 3: underrun on beats 3 and 4
    pushWord(32'hB0000001, 4'h5);
    pushWord(32'hB0000002, 4'hA);
    exp_data[0] = 32'hB0000001; exp_mask[0] = 4'h5;
    exp_data[1] = 32'hB0000002; exp_mask[1] = 4'hA;
    exp_data[2] = 32'h0;        exp_mask[2] = 4'hF;
    exp_data[3] = 32'h0;        exp_mask[3] = 4'hF;
    runBurst(3'd2, 4, "t3");
    checkOutput("t3_underrun", underrun, 1'b1);
    idleCycle();
    checkOutput("t3_underrun_sticky", underrun, 1'b1);
    applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, 3'd0, 1'b1);
    checkOutput("t3_underrun_clr", underrun, 1'b0);

    // 4: push during an 8-beat burst, pointers wrap, mid-burst start ignored
    for (int k = 1; k <= 4; k++) pushWord(32'hC0000000 + 32'(k), 4'h0);
    applyStimulus(1'b1, 32'hC0000005, 4'h0, 1'b1, 3'd3, 1'b0);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("t4_oe%0d", i), dq_oe, 1'b1);
      checkOutput($sformatf("t4_dq%0d", i), dq_out, 32'hC0000000 + 32'(i + 1));
      checkOutput($sformatf("t4_count%0d", i), fifo_count, 4'd4);
      if (i == 3) checkOutput("t4_serr_before", start_err, 1'b0);
      if (i == 4) checkOutput("t4_serr_set", start_err, 1'b1);
      if (i < 7) applyStimulus(1'b1, 32'hC0000000 + 32'(i + 6), 4'h0, (i == 3), 3'd0, 1'b0);
    end
    idleCycle();
    checkOutput("t4_turn_oe", dq_oe, 1'b0);
    checkOutput("t4_turn_count", fifo_count, 4'd4);
    idleCycle();
    checkOutput("t4_idle_busy", wr_busy, 1'b0);
    for (int i = 0; i < 4; i++) begin
      exp_data[i] = 32'hC0000000 + 32'(i + 9);
      exp_mask[i] = 4'h0;
    end
    runBurst(3'd2, 4, "t4drain");
    checkOutput("t4_serr_sticky", start_err, 1'b1);
    applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, 3'd0, 1'b1);
    checkOutput("t4_serr_clr", start_err, 1'b0);

    // 5: reset on beat 2 of a 4-beat burst
    for (int k = 1; k <= 4; k++) pushWord(32'hD0000000 + 32'(k), 4'h0);
    applyStimulus(1'b0, 32'h0, 4'h0, 1'b1, 3'd2, 1'b0);
    checkOutput("t5_beat1", dq_out, 32'hD0000001);
    applyStimulus(1'b0, 32'h0, 4'h0, 1'b1, 3'd0, 1'b0);
    checkOutput("t5_beat2", dq_out, 32'hD0000002);
    checkOutput("t5_serr_pre", start_err, 1'b1);
    reset = 1'b1;
    tick();
    checkOutput("t5_rst_oe", dq_oe, 1'b0);
    checkOutput("t5_rst_count", fifo_count, 4'd0);
    checkOutput("t5_rst_busy", wr_busy, 1'b0);
    checkOutput("t5_rst_flags", {underrun, start_err}, 2'b00);
    reset = 1'b0;
    idleCycle();
    checkOutput("t5_post_oe", dq_oe, 1'b0);
    checkOutput("t5_post_ready", wr_ready, 1'b1);

    // 6: burst code 5 behaves as 8 beats
    for (int k = 1; k <= 8; k++) pushWord(32'hE0000000 + 32'(k), 4'(k));
    for (int i = 0; i < 8; i++) begin
      exp_data[i] = 32'hE0000000 + 32'(i + 1);
      exp_mask[i] = 4'(i + 1);
    end
    runBurst(3'd5, 8, "t6");
    checkOutput("t6_count_end", fifo_count, 4'd0);
    checkOutput("t6_underrun", underrun, 1'b0);

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
